// File: rtl/ram_word_controller.sv
//============================================================================
// Module      : ram_word_controller
// Description : Turns word-level read/write requests into one-hot row select,
//               write/read strobes and data-in for a BinaryCell array, and
//               returns read data (or echoed write data) on a valid/ready
//               response channel. Counts completed transactions.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ram_word_controller #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [2**ADDR_W-1:0] cell_cs,
    output logic                 cell_w,
    output logic                 cell_r,
    output logic [DATA_W-1:0]    cell_din,
    input  logic [DATA_W-1:0]    cell_dout,
    output logic [7:0]           op_cnt
);

    localparam int ROWS = 2**ADDR_W;
    localparam logic [ROWS-1:0] C_ROW0 = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WRITE   = 3'd2,
        RECOVER = 3'd3,
        READ    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic                r_we,     w_we_nxt;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;
    logic                w_req_ready_nxt, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt, w_cell_din_nxt;
    logic [ROWS-1:0]     w_cell_cs_nxt;
    logic                w_cell_w_nxt, w_cell_r_nxt;
    logic [7:0]          w_op_cnt_nxt;

    // State and all outputs are registered together so every output reflects the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            cell_cs   <= '0;
            cell_w    <= 1'b0;
            cell_r    <= 1'b0;
            cell_din  <= '0;
            op_cnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_we      <= w_we_nxt;
            r_wdata   <= w_wdata_nxt;
            req_ready <= w_req_ready_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_rdata <= w_rsp_rdata_nxt;
            cell_cs   <= w_cell_cs_nxt;
            cell_w    <= w_cell_w_nxt;
            cell_r    <= w_cell_r_nxt;
            cell_din  <= w_cell_din_nxt;
            op_cnt    <= w_op_cnt_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state says otherwise
    always_comb begin
        w_state_nxt     = r_state;
        w_we_nxt        = r_we;
        w_wdata_nxt     = r_wdata;
        w_req_ready_nxt = req_ready;
        w_rsp_valid_nxt = rsp_valid;
        w_rsp_rdata_nxt = rsp_rdata;
        w_cell_cs_nxt   = cell_cs;
        w_cell_w_nxt    = 1'b0;
        w_cell_r_nxt    = 1'b0;
        w_cell_din_nxt  = cell_din;
        w_op_cnt_nxt    = op_cnt;

        unique case (r_state)
            IDLE: begin
                // req_ready is 0 only on the first cycle after reset release
                w_req_ready_nxt = 1'b1;
                w_cell_cs_nxt   = '0;
                w_cell_din_nxt  = '0;
                if (req_valid && req_ready) begin
                    w_state_nxt     = SETUP;
                    w_req_ready_nxt = 1'b0;
                    w_we_nxt        = req_we;
                    w_wdata_nxt     = req_wdata;
                    w_cell_cs_nxt   = C_ROW0 << req_addr;
                    w_cell_din_nxt  = req_we ? req_wdata : '0;
                end
            end
            SETUP: begin
                // Row select has settled for a cycle before any strobe rises
                w_state_nxt  = r_we ? WRITE : READ;
                w_cell_w_nxt = r_we;
                w_cell_r_nxt = ~r_we;
            end
            WRITE: begin
                w_state_nxt = RECOVER;
            end
            RECOVER: begin
                w_state_nxt     = RESP;
                w_cell_cs_nxt   = '0;
                w_cell_din_nxt  = '0;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = r_wdata;
            end
            READ: begin
                // Row data is valid while cell_r is high; capture it on the way out
                w_state_nxt     = RESP;
                w_cell_cs_nxt   = '0;
                w_cell_din_nxt  = '0;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = cell_dout;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_op_cnt_nxt    = op_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_cell_cs_nxt   = '0;
                w_cell_din_nxt  = '0;
            end
        endcase
    end

endmodule

`default_nettype wire
